uart_cmd_rx_fifo: RTL and testbench
===================================

Name: uart_cmd_rx_fifo

Overview:
Parametrised UART command receiver, the successor to the single-register command receiver. It contains its own oversampling RX deserialiser with configurable parity and stop bits, and detects framing errors, parity errors and line breaks. Good frames are buffered in a FIFO with a valid/ready pop interface. It sits between the board UART pin and the RGB command decoder, so bursts of commands are no longer lost when the decoder stalls.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BIT_RATE, 256000, line rate in baud; CPB = CLK_HZ/BIT_RATE (integer division, must be >= 4)
PAYLOAD_BITS, 8, data bits per frame, range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, command FIFO entries, power of 2, >= 2
RESET_CMD, 8'hF0, reset value of last_cmd (zero-extended/truncated to PAYLOAD_BITS)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rxd  in  1  serial input, idle high, asynchronous to clk
rx_en  in  1  receiver enable; sampled only in IDLE
cmd_data  out  PAYLOAD_BITS  FIFO head word
cmd_valid  out  1  FIFO not empty
cmd_ready  in  1  consumer pops head when cmd_valid && cmd_ready
last_cmd  out  PAYLOAD_BITS  most recently pushed command
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  out  1  one-cycle pulse: stop bit sampled low
parity_err  out  1  one-cycle pulse: parity mismatch
overflow  out  1  one-cycle pulse: good frame dropped because FIFO full
break_det  out  1  one-cycle pulse: break detected

Behaviour:
- Reset (async, rst_n low):
  - FSM to IDLE; FIFO empty; cmd_valid = 0; fifo_count = 0.
  - cmd_data = 0; last_cmd = RESET_CMD; all error pulses = 0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame discards the partial frame; no pulse is emitted.
- uart_rxd passes through a 2-flop synchroniser. All sampling uses the synchronised signal (rxs), adding 2 cycles of latency.
- Bit timer counts 0..CPB-1. Samples are taken at the mid-bit point, CPB/2 cycles after the bit start.
- FSM states:
  - IDLE: when rx_en = 1 and rxs = 0, go to START and clear the timer. When rx_en = 0, stay in IDLE regardless of the line.
  - START: at CPB/2, if rxs = 1 (glitch) go to IDLE with no pulse. Otherwise re-arm the timer for full-bit steps and go to DATA.
  - DATA: sample PAYLOAD_BITS bits, LSB first, one every CPB cycles. Then go to PARITY if PARITY != 0, else to STOP.
  - PARITY: sample one bit. Expected value is the XOR of the data bits, inverted for odd parity. Store the mismatch flag.
  - STOP: sample STOP_BITS bits. Then evaluate the frame on the final stop sample cycle (priority order):
    1. All data bits = 0, parity bit (if any) = 0, and any stop sample = 0 → break_det pulse, go to BREAK.
    2. Otherwise, any stop sample = 0 → frame_err pulse, no push, go to IDLE.
    3. Otherwise, parity mismatch → parity_err pulse, no push, go to IDLE.
    4. Otherwise the frame is good: push it, go to IDLE.
  - BREAK: wait until rxs = 1, then go to IDLE. No further pulses.
- Push of a good frame:
  - The word is written on the clock edge of the final stop sample.
  - last_cmd updates on the same edge.
  - If the FIFO was empty, cmd_valid rises and cmd_data shows the word the following cycle.
- FIFO is first-word-fall-through. cmd_data always equals the head; it holds its value when empty.
- Pop when cmd_valid && cmd_ready; cmd_ready is ignored while cmd_valid = 0.
- Full FIFO:
  - Push without pop → word dropped, overflow pulse; last_cmd is not updated.
  - Push and pop in the same cycle → both occur, no overflow, count unchanged.
- Empty FIFO with push: pop is impossible that cycle, so there is no bypass.
- fifo_count: +1 on push only, −1 on pop only, unchanged on both. Read/write pointers wrap modulo FIFO_DEPTH.
- Pulses are mutually exclusive and last exactly 1 cycle.

Test Plan:
CLK_HZ = 16_000_000, BIT_RATE = 1_000_000 (CPB = 16), 8N1, FIFO_DEPTH = 4 unless stated.
1. Reset, then idle line → last_cmd = 8'hF0, cmd_valid = 0, fifo_count = 0. Send 0xA5 with cmd_ready = 0 → cmd_valid = 1, cmd_data = 0xA5, last_cmd = 0xA5, fifo_count = 1, no pulses.
2. Send 0x01..0x05 back-to-back with cmd_ready = 0 → fifo_count = 4, overflow pulses once on 0x05, last_cmd = 0x04. Then hold cmd_ready = 1 → pops 0x01..0x04 in order, cmd_valid = 0 after the fourth pop.
3. PARITY = 2, send 0x3C with the parity bit forced to 1 → parity_err pulse, FIFO unchanged. Resend with correct parity 0 → word pushed.
4. Send 0x55 with the stop bit driven 0 → frame_err pulse, no push. Hold line low for 30 bit times → break_det pulses exactly once. Release the line, send 0x12 → pushed normally.
5. Low glitch of 5 cycles on the idle line → no state change, no pulse. rx_en = 0 during a frame 0x77 → not received. Assert rst_n low mid-DATA of 0x99 → FIFO empty, last_cmd = 0xF0, next frame 0x42 received correctly.
6. FIFO full (4 words) and cmd_ready = 1 held while 0x66 arrives → push and pop on the same edge, no overflow, fifo_count stays 4, 0x66 is the tail.

Source files
------------

// File: rtl/uart_cmd_rx_fifo.sv
// UART command receiver: 2-flop synchroniser, mid-bit sampling deserialiser with
// optional parity and 1/2 stop bits, break/framing/parity detection, and a
// first-word-fall-through command FIFO with a valid/ready pop side.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge while rx_en is high
// S_START  | confirming the start bit at its mid point (glitch reject)
// S_DATA   | shifting in PAYLOAD_BITS data bits, LSB first
// S_PARITY | sampling the parity bit and latching the mismatch flag
// S_STOP   | sampling stop bit(s); frame verdict on the final sample
// S_BREAK  | line held low after a break, waiting for it to return high
module uart_cmd_rx_fifo #(
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          BIT_RATE     = 256000,
    parameter int          PAYLOAD_BITS = 8,
    parameter int          PARITY       = 0,
    parameter int          STOP_BITS    = 1,
    parameter int          FIFO_DEPTH   = 8,
    parameter int unsigned RESET_CMD    = 8'hF0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            uart_rxd,
    input  logic                            rx_en,
    output logic [PAYLOAD_BITS-1:0]         cmd_data,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [PAYLOAD_BITS-1:0]         last_cmd,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overflow,
    output logic                            break_det
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int TW  = $clog2(CPB) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [TW-1:0]           HALF_TC = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0]           FULL_TC = TW'(CPB - 1);
    localparam logic [PAYLOAD_BITS-1:0] RST_CMD = PAYLOAD_BITS'(RESET_CMD);
    localparam logic                    PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                    state_q, state_d;
    logic                      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0]             tmr_q, tmr_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0]   shift_q, shift_d;
    logic                      par_bit_q, par_bit_d, par_bad_q, par_bad_d;
    logic                      stop_low_q, stop_low_d;
    logic [PAYLOAD_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PAYLOAD_BITS-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [PAYLOAD_BITS-1:0]   cmd_data_q, cmd_data_d, last_cmd_q, last_cmd_d;
    logic                      fe_q, fe_d, pe_q, pe_d, ov_q, ov_d, bk_q, bk_d;
    logic                      rxs, push_req, push, pop, full, stop_any;

    assign rxs = sync2_q;

    // Deserialiser next-state, timer and frame verdict
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q + TW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_bad_d  = par_bad_q;
        stop_low_d = stop_low_q;
        push_req   = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
        bk_d       = 1'b0;
        stop_any   = stop_low_q | ~rxs;
        sync1_d    = uart_rxd;
        sync2_d    = sync1_q;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (rx_en && !rxs) state_d = S_START;
            end
            S_START: begin
                if (tmr_q == HALF_TC) begin
                    tmr_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tmr_q == FULL_TC) begin
                    tmr_d     = '0;
                    shift_d   = {rxs, shift_q[PAYLOAD_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(PAYLOAD_BITS - 1)) begin
                        bit_cnt_d  = '0;
                        par_bit_d  = 1'b0;
                        par_bad_d  = 1'b0;
                        stop_low_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tmr_q == FULL_TC) begin
                    tmr_d     = '0;
                    par_bit_d = rxs;
                    par_bad_d = rxs ^ (^shift_q) ^ PAR_ODD;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tmr_q == FULL_TC) begin
                    tmr_d = '0;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        if ((shift_q == '0) && !par_bit_q && stop_any) begin
                            bk_d    = 1'b1;
                            state_d = S_BREAK;
                        end else if (stop_any) begin
                            fe_d = 1'b1;
                        end else if (par_bad_q) begin
                            pe_d = 1'b1;
                        end else begin
                            push_req = 1'b1;
                        end
                    end else begin
                        stop_low_d = stop_any;
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_BREAK: begin
                tmr_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers, occupancy, head register and overflow decision
    always_comb begin
        pop        = (count_q != '0) && cmd_ready;
        full       = (count_q == CW'(FIFO_DEPTH));
        push       = push_req && (!full || pop);
        ov_d       = push_req && full && !pop;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cmd_data_d = cmd_data_q;
        last_cmd_d = last_cmd_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            last_cmd_d      = shift_q;
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
        // Head register holds its last value when the FIFO drains empty.
        if (pop) begin
            if (count_q == CW'(1)) begin
                if (push) cmd_data_d = shift_q;
            end else begin
                cmd_data_d = mem_q[rd_ptr_q + AW'(1)];
            end
        end else if ((count_q == '0) && push) begin
            cmd_data_d = shift_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            tmr_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_low_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_data_q <= '0;
            last_cmd_q <= RST_CMD;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
            bk_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tmr_q      <= tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_bad_q  <= par_bad_d;
            stop_low_q <= stop_low_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cmd_data_q <= cmd_data_d;
            last_cmd_q <= last_cmd_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ov_q       <= ov_d;
            bk_q       <= bk_d;
        end
    end

    assign cmd_data   = cmd_data_q;
    assign cmd_valid  = (count_q != '0);
    assign last_cmd   = last_cmd_q;
    assign fifo_count = count_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overflow   = ov_q;
    assign break_det  = bk_q;
endmodule

// File: tb/tb_uart_cmd_rx_fifo.sv
// Bench for uart_cmd_rx_fifo: an 8N1 and an 8E1 instance (CPB = 16, depth 4),
// driven by directed frames and a randomized burst, checked against a
// queue-based model of the command FIFO and the frame classification rules.
module tb_uart_cmd_rx_fifo;
    localparam int CPB = 16;
    localparam int DEPTH = 4;
    localparam int C_GOOD = 0, C_PAR = 1, C_FRM = 2, C_BRK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rxd [2];
    logic       en [2];
    logic       rdy [2];
    logic [7:0] data [2];
    logic       valid [2];
    logic [7:0] last [2];
    logic [2:0] cnt [2];
    logic       fe [2], pe [2], ov [2], bk [2];

    uart_cmd_rx_fifo #(.CLK_HZ(16_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .RESET_CMD(8'hF0)) u_dut_8n1 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_en(en[0]),
        .cmd_data(data[0]), .cmd_valid(valid[0]), .cmd_ready(rdy[0]), .last_cmd(last[0]),
        .fifo_count(cnt[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overflow(ov[0]),
        .break_det(bk[0]));

    uart_cmd_rx_fifo #(.CLK_HZ(16_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .RESET_CMD(8'hF0)) u_dut_8e1 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_en(en[1]),
        .cmd_data(data[1]), .cmd_valid(valid[1]), .cmd_ready(rdy[1]), .last_cmd(last[1]),
        .fifo_count(cnt[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overflow(ov[1]),
        .break_det(bk[1]));

    int n_checks = 0, n_pass = 0;
    int cyc = 0, start_cyc = 0, pulse_off = -1, push_lat = 0;
    int fe_n [2] = '{0, 0};
    int pe_n [2] = '{0, 0};
    int ov_n [2] = '{0, 0};
    int bk_n [2] = '{0, 0};
    int multi_n = 0;
    int chg_cyc0 = 0;
    logic [7:0] prev_last0 = 8'hF0;
    logic [7:0] got0 [$], got1 [$], exp0 [$], exp1 [$];
    logic [7:0] mlast [2];

    // Pulse counters and pop capture, sampled at the edge the DUT acts on
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (fe[d]) fe_n[d] <= fe_n[d] + 1;
            if (pe[d]) pe_n[d] <= pe_n[d] + 1;
            if (ov[d]) ov_n[d] <= ov_n[d] + 1;
            if (bk[d]) bk_n[d] <= bk_n[d] + 1;
            if ((int'(fe[d]) + int'(pe[d]) + int'(ov[d]) + int'(bk[d])) > 1) multi_n <= multi_n + 1;
        end
        if (valid[0] && rdy[0]) got0.push_back(data[0]);
        if (valid[1] && rdy[1]) got1.push_back(data[1]);
    end

    // Records the edge on which last_cmd of the 8N1 instance changed
    always @(negedge clk) begin
        if (last[0] !== prev_last0) chg_cyc0 <= cyc;
        prev_last0 <= last[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int d);
        @(negedge clk);
        if (d == 0 && pulse_off >= 0) rdy[0] = ((cyc - start_cyc) == pulse_off - 1);
    endtask

    task automatic drive_bit(input int d, input logic b);
        rxd[d] = b;
        repeat (CPB) tick(d);
    endtask

    task automatic send(input int d, input logic [7:0] w, input int par, input bit flip, input logic stopv);
        @(negedge clk);
        rxd[d] = 1'b0;
        start_cyc = cyc;
        repeat (CPB) tick(d);
        for (int i = 0; i < 8; i++) drive_bit(d, w[i]);
        if (par != 0) drive_bit(d, (^w) ^ (par == 1) ^ flip);
        drive_bit(d, stopv);
    endtask

    function automatic int classify(input logic [7:0] w, input bit has_par, input logic pbit,
                                    input int par, input bit stop_low);
        logic exp_p;
        exp_p = (^w) ^ (par == 1);
        if (w == 8'h00 && (!has_par || pbit == 1'b0) && stop_low) return C_BRK;
        if (stop_low) return C_FRM;
        if (has_par && pbit != exp_p) return C_PAR;
        return C_GOOD;
    endfunction

    function automatic int exp_size(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic int got_size(input int d);
        return (d == 0) ? got0.size() : got1.size();
    endfunction

    task automatic consume(input int d, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [31:0] g, e;
            e = 32'hDEAD_BEEF;
            if (d == 0) begin
                g = 32'(got0.pop_front());
                if (exp0.size() != 0) e = 32'(exp0.pop_front());
            end else begin
                g = 32'(got1.pop_front());
                if (exp1.size() != 0) e = 32'(exp1.pop_front());
            end
            chk({tag, "/pop_order"}, g, e);
        end
    endtask

    // Pops seen before the push belong to old words; the rest follow it.
    task automatic reconcile(input int d, input bit good, input logic [7:0] w,
                             input string tag, output bit ov_exp);
        int n;
        n = (got_size(d) < exp_size(d)) ? got_size(d) : exp_size(d);
        consume(d, n, tag);
        ov_exp = 1'b0;
        if (good) begin
            if (exp_size(d) < DEPTH) begin
                if (d == 0) exp0.push_back(w); else exp1.push_back(w);
                mlast[d] = w;
            end else begin
                ov_exp = 1'b1;
            end
        end
        consume(d, got_size(d), tag);
    endtask

    task automatic check_state(input int d, input string tag);
        chk({tag, "/fifo_count"}, 32'(cnt[d]), 32'(exp_size(d)));
        chk({tag, "/cmd_valid"}, 32'(valid[d]), 32'(exp_size(d) != 0));
        chk({tag, "/last_cmd"}, 32'(last[d]), 32'(mlast[d]));
        if (exp_size(d) != 0)
            chk({tag, "/cmd_data"}, 32'(data[d]), 32'((d == 0) ? exp0[0] : exp1[0]));
    endtask

    task automatic frame(input int d, input logic [7:0] w, input bit flip, input logic stopv,
                         input string tag);
        int f0, p0, o0, b0, par, cls;
        bit ov_exp;
        logic pbit;
        f0 = fe_n[d]; p0 = pe_n[d]; o0 = ov_n[d]; b0 = bk_n[d];
        par = (d == 1) ? 2 : 0;
        send(d, w, par, flip, stopv);
        repeat (2) @(negedge clk);
        pbit = (par != 0) ? ((^w) ^ flip) : 1'b0;
        cls = classify(w, par != 0, pbit, par, !stopv);
        reconcile(d, cls == C_GOOD, w, tag, ov_exp);
        chk({tag, "/frame_err"}, 32'(fe_n[d] - f0), 32'(cls == C_FRM));
        chk({tag, "/parity_err"}, 32'(pe_n[d] - p0), 32'(cls == C_PAR));
        chk({tag, "/break_det"}, 32'(bk_n[d] - b0), 32'(cls == C_BRK));
        chk({tag, "/overflow"}, 32'(ov_n[d] - o0), 32'(ov_exp));
        check_state(d, tag);
    endtask

    task automatic drain(input int d, input string tag);
        bit dummy;
        rdy[d] = 1'b1;
        repeat (10) @(negedge clk);
        rdy[d] = 1'b0;
        @(negedge clk);
        reconcile(d, 1'b0, 8'h00, tag, dummy);
        check_state(d, tag);
    endtask

    initial begin
        int s_fe, s_pe, s_ov, s_bk;
        logic [7:0] rw;
        bit rflip;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rxd[d] = 1'b1; en[d] = 1'b1; rdy[d] = 1'b0; mlast[d] = 8'hF0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: reset state, then a single frame with the consumer stalled
        for (int d = 0; d < 2; d++) begin
            chk("reset/last_cmd", 32'(last[d]), 32'h00F0);
            chk("reset/cmd_valid", 32'(valid[d]), 32'd0);
            chk("reset/fifo_count", 32'(cnt[d]), 32'd0);
            chk("reset/cmd_data", 32'(data[d]), 32'd0);
        end
        frame(0, 8'hA5, 1'b0, 1'b1, "t1_a5");
        push_lat = chg_cyc0 - start_cyc;

        // 2: fill past capacity, then drain in order
        rdy[0] = 1'b1;
        repeat (3) @(negedge clk);
        rdy[0] = 1'b0;
        drain(0, "t2_predrain");
        for (int i = 1; i <= 5; i++) frame(0, 8'(i), 1'b0, 1'b1, "t2_fill");
        chk("t2/overflow_total", 32'(ov_n[0]), 32'd1);
        drain(0, "t2_drain");
        chk("t2/cmd_data_held", 32'(data[0]), 32'h04);

        // 3: even parity, bad then good parity bit
        frame(1, 8'h3C, 1'b1, 1'b1, "t3_badpar");
        frame(1, 8'h3C, 1'b0, 1'b1, "t3_goodpar");

        // 4: framing error, break, recovery
        frame(0, 8'h55, 1'b0, 1'b0, "t4_frame");
        s_fe = fe_n[0]; s_bk = bk_n[0];
        repeat (30 * CPB) @(negedge clk);
        chk("t4/break_once", 32'(bk_n[0] - s_bk), 32'd1);
        chk("t4/no_more_frame_err", 32'(fe_n[0] - s_fe), 32'd0);
        rxd[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("t4/break_still_once", 32'(bk_n[0] - s_bk), 32'd1);
        check_state(0, "t4_after_break");
        frame(0, 8'h12, 1'b0, 1'b1, "t4_recover");

        // 5: glitch, disabled receiver, reset mid-frame
        s_fe = fe_n[0]; s_pe = pe_n[0]; s_ov = ov_n[0]; s_bk = bk_n[0];
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (40) @(negedge clk);
        en[0] = 1'b0;
        send(0, 8'h77, 0, 1'b0, 1'b1);
        en[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5/no_pulses", 32'((fe_n[0] - s_fe) + (pe_n[0] - s_pe) + (ov_n[0] - s_ov) + (bk_n[0] - s_bk)), 32'd0);
        check_state(0, "t5_glitch_disabled");
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (CPB) @(negedge clk);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rst_n = 1'b0;
        rxd[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
        mlast[0] = 8'hF0; mlast[1] = 8'hF0;
        repeat (3 * CPB) @(negedge clk);
        chk("t5/reset_no_pulses", 32'((fe_n[0] - s_fe) + (pe_n[0] - s_pe) + (ov_n[0] - s_ov) + (bk_n[0] - s_bk)), 32'd0);
        chk("t5/reset_cmd_data", 32'(data[0]), 32'd0);
        check_state(0, "t5_reset");
        check_state(1, "t5_reset_8e1");
        frame(0, 8'h42, 1'b0, 1'b1, "t5_42");

        // 6: full FIFO with a pop landing on the push edge
        frame(0, 8'h02, 1'b0, 1'b1, "t6_fill");
        frame(0, 8'h03, 1'b0, 1'b1, "t6_fill");
        frame(0, 8'h04, 1'b0, 1'b1, "t6_fill");
        chk("t6/full_before", 32'(cnt[0]), 32'd4);
        pulse_off = push_lat;
        frame(0, 8'h66, 1'b0, 1'b1, "t6_push_pop");
        pulse_off = -1;
        rdy[0] = 1'b0;
        chk("t6/count_stays_full", 32'(cnt[0]), 32'd4);
        drain(0, "t6_drain");

        // randomized frames on the parity instance with a random consumer
        for (int i = 0; i < 12; i++) begin
            rdy[1] = 1'($urandom_range(0, 1));
            rw = 8'($urandom);
            rflip = ($urandom_range(0, 3) == 0);
            frame(1, rw, rflip, 1'b1, "rand");
        end
        rdy[1] = 1'b0;
        drain(1, "rand_drain");

        chk("pulses_exclusive", 32'(multi_n), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
